// File: rtl/bht_update_unit.sv
// Branch history table: one 2-bit saturating counter per entry, indexed by PC.
// Execute-stage branch outcomes train the table, the fetch stage reads registered
// predictions one cycle after a lookup, and a flush engine clears one entry per cycle.
module bht_update_unit #(
  parameter int unsigned VLEN       = 64,
  parameter int unsigned NR_ENTRIES = 256,
  parameter int unsigned OFFSET     = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_bp_i,
  input  logic            lookup_valid_i,
  input  logic [VLEN-1:0] lookup_pc_i,
  output logic            bht_valid_o,
  output logic            bht_taken_o,
  input  logic            upd_valid_i,
  input  logic [VLEN-1:0] upd_pc_i,
  input  logic            upd_is_branch_i,
  input  logic            upd_is_taken_i,
  output logic            ready_o
);

  localparam int unsigned      IDX_W = $clog2(NR_ENTRIES);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NR_ENTRIES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] cnt_next;

  logic             entry_valid [NR_ENTRIES];
  logic [1:0]       entry_ctr   [NR_ENTRIES];

  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] lkp_idx;
  logic             upd_en;
  logic [1:0]       upd_ctr;
  logic             lkp_hit;
  logic             lkp_valid;
  logic [1:0]       lkp_ctr;

  // Upper PC bits are deliberately discarded, so aliasing entries share a counter.
  logic             unused_pc_bits;

  assign upd_idx = upd_pc_i[OFFSET+IDX_W-1:OFFSET];
  assign lkp_idx = lookup_pc_i[OFFSET+IDX_W-1:OFFSET];
  assign unused_pc_bits = ^{lookup_pc_i[VLEN-1:OFFSET+IDX_W], lookup_pc_i[OFFSET-1:0],
                            upd_pc_i[VLEN-1:OFFSET+IDX_W], upd_pc_i[OFFSET-1:0]};

  assign ready_o = (state == IDLE);

  // A flush request in IDLE takes priority, so a simultaneous update is dropped.
  assign upd_en = upd_valid_i & upd_is_branch_i & ready_o & ~flush_bp_i;

  // Post-update counter value: a fresh entry starts weak, a trained one saturates.
  always_comb begin
    upd_ctr = entry_ctr[upd_idx];
    if (!entry_valid[upd_idx]) begin
      upd_ctr = upd_is_taken_i ? 2'b10 : 2'b01;
    end else if (upd_is_taken_i) begin
      upd_ctr = (entry_ctr[upd_idx] == 2'b11) ? 2'b11 : entry_ctr[upd_idx] + 2'b01;
    end else begin
      upd_ctr = (entry_ctr[upd_idx] == 2'b00) ? 2'b00 : entry_ctr[upd_idx] - 2'b01;
    end
  end

  // Lookup data with write-first bypass when the update hits the same entry.
  always_comb begin
    lkp_hit   = upd_en && (upd_idx == lkp_idx);
    lkp_valid = lkp_hit ? 1'b1 : entry_valid[lkp_idx];
    lkp_ctr   = lkp_hit ? upd_ctr : entry_ctr[lkp_idx];
  end

  // Flush FSM next-state logic; a new flush request always restarts from entry 0.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (flush_bp_i) begin
          state_next = FLUSH;
          cnt_next   = '0;
        end
      end
      FLUSH: begin
        if (flush_bp_i) begin
          cnt_next = '0;
        end else if (cnt == LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + IDX_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Flush FSM state and entry counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Table storage: cleared by reset, one entry per cycle while flushing, else trained.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        entry_valid[i] <= 1'b0;
        entry_ctr[i]   <= 2'b01;
      end
    end else if (state == FLUSH) begin
      entry_valid[cnt] <= 1'b0;
      entry_ctr[cnt]   <= 2'b01;
    end else if (upd_en) begin
      entry_valid[upd_idx] <= 1'b1;
      entry_ctr[upd_idx]   <= upd_ctr;
    end
  end

  // Registered prediction; taken is only reported alongside a valid prediction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bht_valid_o <= 1'b0;
      bht_taken_o <= 1'b0;
    end else begin
      bht_valid_o <= lookup_valid_i & ready_o & lkp_valid;
      bht_taken_o <= lookup_valid_i & ready_o & lkp_valid & lkp_ctr[1];
    end
  end

endmodule

// File: tb/tb_bht_update_unit.sv
// Scoreboard bench for bht_update_unit: a behavioural table model predicts every
// registered prediction and the ready flag; flush lengths are counted directly.
module tb_bht_update_unit;

  localparam int ENTRIES = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_bp = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [63:0] lookup_pc = '0;
  logic        bht_valid;
  logic        bht_taken;
  logic        upd_valid = 1'b0;
  logic [63:0] upd_pc = '0;
  logic        upd_is_branch = 1'b0;
  logic        upd_is_taken = 1'b0;
  logic        ready;

  int errors = 0;
  int checks = 0;

  // Reference model of the table and flush engine
  bit       mvalid [ENTRIES];
  bit [1:0] mctr   [ENTRIES];
  bit       mflushing;
  int       mcnt;

  logic [1:0] expq[$];

  bht_update_unit #(.VLEN(64), .NR_ENTRIES(ENTRIES), .OFFSET(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_bp_i(flush_bp),
    .lookup_valid_i(lookup_valid),
    .lookup_pc_i(lookup_pc),
    .bht_valid_o(bht_valid),
    .bht_taken_o(bht_taken),
    .upd_valid_i(upd_valid),
    .upd_pc_i(upd_pc),
    .upd_is_branch_i(upd_is_branch),
    .upd_is_taken_i(upd_is_taken),
    .ready_o(ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int idxOf(input logic [63:0] pc);
    return int'(pc[9:2]);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) begin
      mvalid[i] = 1'b0;
      mctr[i]   = 2'b01;
    end
    mflushing = 1'b0;
    mcnt      = 0;
    expq.delete();
  endtask

  // Drive one cycle, predict its outcome, then compare after the clock edge.
  task automatic applyStimulus(input bit lv, input logic [63:0] lpc, input bit uv,
                               input logic [63:0] upc, input bit br, input bit tk,
                               input bit fl);
    int       li;
    int       ui;
    bit       mrdy;
    bit       upd;
    bit       hit;
    bit       ev;
    bit [1:0] nc;
    bit [1:0] ec;
    logic [1:0] e;
    @(negedge clk);
    lookup_valid  = lv;
    lookup_pc     = lpc;
    upd_valid     = uv;
    upd_pc        = upc;
    upd_is_branch = br;
    upd_is_taken  = tk;
    flush_bp      = fl;
    li   = idxOf(lpc);
    ui   = idxOf(upc);
    mrdy = !mflushing;
    upd  = uv && br && mrdy && !fl;
    if (!mvalid[ui])    nc = tk ? 2'b10 : 2'b01;
    else if (tk)        nc = (mctr[ui] == 2'b11) ? 2'b11 : mctr[ui] + 2'b01;
    else                nc = (mctr[ui] == 2'b00) ? 2'b00 : mctr[ui] - 2'b01;
    hit = upd && (li == ui);
    ev  = lv && mrdy && (hit ? 1'b1 : mvalid[li]);
    ec  = hit ? nc : mctr[li];
    expq.push_back({ev, ev & ec[1]});
    if (mflushing) begin
      mvalid[mcnt] = 1'b0;
      mctr[mcnt]   = 2'b01;
      if (fl)                      mcnt = 0;
      else if (mcnt == ENTRIES-1)  begin mflushing = 1'b0; mcnt = 0; end
      else                         mcnt++;
    end else if (fl) begin
      mflushing = 1'b1;
      mcnt      = 0;
    end else if (upd) begin
      mvalid[ui] = 1'b1;
      mctr[ui]   = nc;
    end
    @(posedge clk);
    #1;
    if (expq.size() == 0) begin
      checkOutput("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = expq.pop_front();
      checkOutput("bht_pred", {62'd0, bht_valid, bht_taken}, {62'd0, e});
    end
    checkOutput("ready", {63'd0, ready}, {63'd0, !mflushing});
  endtask

  task automatic idle();
    applyStimulus(0, 64'd0, 0, 64'd0, 0, 0, 0);
  endtask

  task automatic update(input logic [63:0] pc, input bit tk);
    applyStimulus(0, 64'd0, 1, pc, 1, tk, 0);
  endtask

  task automatic lookup(input logic [63:0] pc);
    applyStimulus(1, pc, 0, 64'd0, 0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    lookup_valid = 0; upd_valid = 0; upd_is_branch = 0; upd_is_taken = 0; flush_bp = 0;
    modelReset();
    #1;
    checkOutput("rst_valid", {63'd0, bht_valid}, 64'd0);
    checkOutput("rst_taken", {63'd0, bht_taken}, 64'd0);
    checkOutput("rst_ready", {63'd0, ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", {63'd0, ready}, 64'd1);
  endtask

  task automatic populate();
    for (int i = 0; i < 32; i++) update(64'h8000_0000 + 64'(i * 4), 1'b1);
  endtask

  initial begin
    int low;
    modelReset();
    rst = 1'b1;
    #12;
    doReset();

    // 1: two taken updates then a lookup -> strongly taken
    update(64'h8000_0010, 1);
    update(64'h8000_0010, 1);
    lookup(64'h8000_0010);
    checkOutput("t1_valid", {63'd0, bht_valid}, 64'd1);
    checkOutput("t1_taken", {63'd0, bht_taken}, 64'd1);

    // 2: saturation up and down
    for (int i = 0; i < 4; i++) update(64'h8000_0020, 1);
    update(64'h8000_0020, 0);
    lookup(64'h8000_0020);
    checkOutput("t2_taken_10", {63'd0, bht_taken}, 64'd1);
    update(64'h8000_0020, 0);
    update(64'h8000_0020, 0);
    lookup(64'h8000_0020);
    checkOutput("t2_taken_00", {63'd0, bht_taken}, 64'd0);
    update(64'h8000_0020, 0);
    update(64'h8000_0020, 1);
    lookup(64'h8000_0020);
    checkOutput("t2_floor", {62'd0, bht_valid, bht_taken}, 64'd2);

    // Non-branch and invalid records leave the entry untouched
    applyStimulus(0, 64'd0, 1, 64'h8000_0030, 0, 1, 0);
    applyStimulus(0, 64'd0, 0, 64'h8000_0030, 1, 1, 0);
    lookup(64'h8000_0030);
    checkOutput("ignored_upd", {63'd0, bht_valid}, 64'd0);

    // 3: aliasing through dropped upper PC bits
    update(64'h8000_0010, 1);
    lookup(64'h8000_0010 + 64'(ENTRIES * 4));
    checkOutput("t3_alias", {62'd0, bht_valid, bht_taken}, 64'd3);

    // 4: write-first on a first-ever update
    applyStimulus(1, 64'h40, 1, 64'h40, 1, 1, 0);
    checkOutput("t4_wfirst", {62'd0, bht_valid, bht_taken}, 64'd3);

    // Flush request alongside an update: update dropped
    applyStimulus(1, 64'h80, 1, 64'h80, 1, 1, 1);
    low = ready ? 0 : 1;
    for (int k = 0; k < 400 && !ready; k++) begin
      idle();
      if (!ready) low++;
    end
    checkOutput("flush_drop_len", 64'(low), 64'd256);
    lookup(64'h80);
    checkOutput("flush_drop_upd", {63'd0, bht_valid}, 64'd0);

    // 5: flush with traffic in the window, then the whole table reads invalid
    populate();
    applyStimulus(0, 64'd0, 0, 64'd0, 0, 0, 1);
    low = ready ? 0 : 1;
    for (int k = 0; k < 400 && !ready; k++) begin
      applyStimulus(1, 64'h8000_0000 + 64'((k % 32) * 4), 1,
                    64'h8000_0000 + 64'((k % 32) * 4), 1, 1, 0);
      if (!ready) low++;
    end
    checkOutput("t5_flush_len", 64'(low), 64'd256);
    for (int i = 0; i < ENTRIES; i++) lookup(64'h8000_0000 + 64'(i * 4));

    // 6: reset mid-flush, then a restarted flush
    populate();
    applyStimulus(0, 64'd0, 0, 64'd0, 0, 0, 1);
    for (int k = 0; k < 100; k++) idle();
    doReset();
    for (int i = 0; i < 32; i++) lookup(64'h8000_0000 + 64'(i * 4));
    populate();
    applyStimulus(0, 64'd0, 0, 64'd0, 0, 0, 1);
    low = ready ? 0 : 1;
    for (int k = 0; k < 600 && !ready; k++) begin
      applyStimulus(0, 64'd0, 0, 64'd0, 0, 0, low == 50);
      if (!ready) low++;
    end
    checkOutput("t6_restart_len", 64'(low), 64'd306);
    for (int i = 0; i < 32; i++) lookup(64'h8000_0000 + 64'(i * 4));

    // Table is usable again after the flush
    update(64'h8000_0044, 1);
    lookup(64'h8000_0044);
    checkOutput("post_flush_train", {62'd0, bht_valid, bht_taken}, 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
